// File: rtl/cpu_run_ctrl_if.sv
// Command channel between the host/board debug port and the run controller.
// The host is the master; it issues one command per fire.
interface cpu_run_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] step_n;

  modport master (output cmd_valid, output cmd_op, output step_n, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input step_n, output cmd_ready);
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/debug sequencer for the single-cycle core: gates the CPU clock enable
// for free run / N-step execution and halts on end PC, breakpoint or count limit.
module cpu_run_ctrl #(
  parameter int          CNT_W   = 32,
  parameter logic [31:0] HALT_PC = 32'hF000_0000
) (
  input  logic              clk,
  input  logic              rst,
  cpu_run_ctrl_if.slave     cmd,
  input  logic              bp_en,
  input  logic [31:0]       bp_pc,
  input  logic [CNT_W-1:0]  limit,
  input  logic [31:0]       pc,
  output logic              cpu_en,
  output logic              cpu_rst,
  output logic              halted,
  output logic [2:0]        halt_cause,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_STEP  = 2'b01;
  localparam logic [1:0] OP_HALT  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_USER  = 3'd1;
  localparam logic [2:0] CAUSE_BP    = 3'd2;
  localparam logic [2:0] CAUSE_END   = 3'd3;
  localparam logic [2:0] CAUSE_LIMIT = 3'd4;
  localparam logic [2:0] CAUSE_STEP  = 3'd5;

  logic [1:0]       state_q, state_d;
  logic [2:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rem_q, rem_d;
  logic             skip_q, skip_d;
  logic             crst_q, crst_d;

  logic       active;
  logic [2:0] stop_cause;
  logic       stop_now;
  logic       ready;
  logic       fire;
  logic       en;

  always_comb begin
    active     = (state_q == S_RUN) || (state_q == S_STEP);
    stop_cause = CAUSE_NONE;
    if (active) begin
      if (pc == HALT_PC)
        stop_cause = CAUSE_END;
      else if (bp_en && (pc == bp_pc) && !skip_q)
        stop_cause = CAUSE_BP;
      else if ((limit != '0) && (cnt_q >= limit))
        stop_cause = CAUSE_LIMIT;
    end
    stop_now = (stop_cause != CAUSE_NONE);

    // While executing only HALT/CLEAR are accepted; after END, only CLEAR/HALT restart nothing.
    if (active)
      ready = (cmd.cmd_op == OP_HALT) || (cmd.cmd_op == OP_CLEAR);
    else
      ready = !((cause_q == CAUSE_END) && !cmd.cmd_op[1]);
    fire = cmd.cmd_valid && ready;
    en   = !rst && active && !stop_now && !(fire && cmd.cmd_op[1]);
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    skip_d  = skip_q;
    crst_d  = 1'b0;
    if (fire && (cmd.cmd_op == OP_CLEAR)) begin
      state_d = S_IDLE;
      cause_d = CAUSE_NONE;
      cnt_d   = '0;
      rem_d   = '0;
      skip_d  = 1'b0;
      crst_d  = 1'b1;
    end else begin
      if (en) begin
        if (~&cnt_q) cnt_d = cnt_q + CNT_W'(1);
        skip_d = 1'b0;
        if (state_q == S_STEP) rem_d = rem_q - 8'd1;
      end
      if (active) begin
        if (fire && (cmd.cmd_op == OP_HALT)) begin
          state_d = S_HALTED;
          cause_d = CAUSE_USER;
        end else if (stop_now) begin
          state_d = S_HALTED;
          cause_d = stop_cause;
        end else if ((state_q == S_STEP) && en && (rem_q == 8'd1)) begin
          state_d = S_HALTED;
          cause_d = CAUSE_STEP;
        end
      end else if (fire) begin
        // Resuming from a breakpoint must let that instruction execute once.
        if ((state_q == S_HALTED) && (cause_q == CAUSE_BP)) skip_d = 1'b1;
        case (cmd.cmd_op)
          OP_RUN: begin
            state_d = S_RUN;
            cause_d = CAUSE_NONE;
          end
          OP_STEP: begin
            state_d = S_STEP;
            cause_d = CAUSE_NONE;
            rem_d   = (cmd.step_n == 8'd0) ? 8'd1 : cmd.step_n;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
      rem_q   <= '0;
      skip_q  <= 1'b0;
      crst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      skip_q  <= skip_d;
      crst_q  <= crst_d;
    end
  end

  assign cmd.cmd_ready = ready;
  assign cpu_en        = en;
  assign cpu_rst       = crst_q;
  assign halted        = (state_q == S_HALTED);
  assign halt_cause    = cause_q;
  assign retired_cnt   = cnt_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/debug sequencer for the single-cycle RISC-V core (sccomp).
- Drives a clock-enable into the CPU so it can run freely, single-step N instructions, or stop on command.
- Halts automatically on the end-of-program PC, on a breakpoint PC, or when an instruction-count limit is reached.
- Sits between the board/host debug interface and the sccomp top; exposes the retired-instruction count and the halt cause.

Parameters:
CNT_W, 32, width of retired-instruction counter and limit
HALT_PC, 32'hF000_0000, end-of-program PC; reaching it is a terminal halt

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at rising edge (fire)
cmd_op  in  2  00 RUN, 01 STEP, 10 HALT, 11 CLEAR
step_n  in  8  instructions per STEP; 0 treated as 1
bp_en  in  1  breakpoint enable
bp_pc  in  32  breakpoint address
limit  in  CNT_W  instruction limit; 0 = unlimited
pc  in  32  CPU PC (instruction executed when cpu_en=1)
cpu_en  out  1  CPU clock enable; CPU commits one instruction per cycle with cpu_en=1
cpu_rst  out  1  CPU reset request (registered)
halted  out  1  state==HALTED
halt_cause  out  3  0 NONE, 1 USER, 2 BP, 3 END, 4 LIMIT, 5 STEP
retired_cnt  out  CNT_W  instructions committed since reset/CLEAR

Behaviour:
Reset:
- state IDLE, halt_cause 0, retired_cnt 0, step_rem 0, bp_skip 0, cpu_rst 1.
- cpu_en and halted are 0.
- cpu_rst remains 1 for the first cycle after rst deasserts.

States: IDLE, RUN, STEP, HALTED.

stop_now (combinational, valid only in RUN/STEP). Priority END > BP > LIMIT:
- END: pc==HALT_PC.
- BP: bp_en && pc==bp_pc && !bp_skip.
- LIMIT: limit!=0 && retired_cnt>=limit.

cpu_en = (RUN or STEP) && !stop_now && !(fire && op in {HALT, CLEAR}).
- cpu_en is combinational.
- The instruction at the stopping pc is NOT executed.

On each cycle with cpu_en=1:
- retired_cnt increments, saturating at all-ones.
- bp_skip clears.
- In STEP, step_rem decrements.

cmd_ready:
- 1 in IDLE/HALTED, except RUN/STEP are refused (ready=0) when halt_cause==END.
- In RUN/STEP, 1 only for HALT/CLEAR.

Transitions:
- IDLE/HALTED + RUN fire -> RUN; halt_cause<=0.
- IDLE/HALTED + STEP fire -> STEP; step_rem<=max(step_n,1); halt_cause<=0.
- RUN/STEP/HALT from HALTED with halt_cause==BP: bp_skip<=1, so the breakpoint instruction executes once.
- RUN/STEP + stop_now -> HALTED; cause = winning condition, encoded.
- STEP with cpu_en=1 and step_rem==1 -> HALTED, cause STEP.
- RUN/STEP + HALT fire -> HALTED, cause USER; no instruction commits that cycle.
- HALT fire in IDLE/HALTED: no-op; state and cause unchanged.
- Any state + CLEAR fire -> IDLE; retired_cnt<=0, halt_cause<=0, bp_skip<=0, step_rem<=0, cpu_rst<=1 for exactly one cycle.

Other timing:
- stop_now in the same cycle as the last STEP decrement cannot occur, because stop_now blocks cpu_en.
- RUN while the limit is already reached is accepted; the next cycle halts with cause LIMIT and commits 0 instructions.
- Lowering limit below retired_cnt while running halts on the next cycle.
- rst mid-RUN/STEP: next cycle is IDLE with all reset values; cpu_en is never 1 while rst=1.

Test Plan:
1. Reset, RUN with limit=0, program reaches pc=F000_0000 after 37 instructions → halted=1, cause=3, retired_cnt=37; RUN is then refused (cmd_ready=0); CLEAR gives cpu_rst=1 for 1 cycle, state IDLE, count 0.
2. STEP with step_n=3 from IDLE → cpu_en high for exactly 3 cycles, retired_cnt=3, cause=5. STEP with step_n=0 → 1 instruction.
3. bp_en=1, bp_pc=0x0000_0010, RUN → halts with pc=0x10, retired_cnt=4, cause=2. RUN → 0x10 executes and the core runs on; a later loop back to 0x10 halts again.
4. limit=10, RUN → halts at retired_cnt=10, cause=4. RUN again → 1 cycle in RUN, cpu_en=0 throughout, cause=4. Raise limit to 15 and RUN → stops at 15.
5. HALT fire mid-RUN at retired_cnt=5 → cpu_en=0 in the fire cycle, count stays 5, cause=1. pc==bp_pc and retired_cnt>=limit in the same cycle → cause=2.
6. Assert rst during STEP with step_rem=4 → IDLE, cpu_en=0, retired_cnt=0, cpu_rst=1 through the first post-reset cycle.
